// File: rtl/complex_twiddle_mult_pipe.sv
// Three-stage pipelined complex-by-twiddle multiplier (A * (-j)^q * B) using the
// three-constant, three-multiplier core, with valid/ready flow control and a sideband tag.
module complex_twiddle_mult_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 18,
  parameter int FRAC_BITS  = 14,
  parameter int TAG_WIDTH  = 8,
  parameter logic signed [COEF_WIDTH-1:0] C_PLUS_S = '0,
  parameter logic signed [COEF_WIDTH-1:0] C_ONLY   = '0,
  parameter logic signed [COEF_WIDTH-1:0] C_MIN_S  = '0
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [2*DATA_WIDTH-1:0] i_a,
  input  logic [2:0]              i_typesel,
  input  logic [TAG_WIDTH-1:0]    i_tag,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [2*DATA_WIDTH-1:0] o_r,
  output logic [TAG_WIDTH-1:0]    o_out_tag
);

  // Handshake: a transfer happens on an edge where valid & ready are both high;
  // every stage advances together when the output register is empty or being drained.
  localparam int DW = DATA_WIDTH;
  localparam int PW = DATA_WIDTH + COEF_WIDTH + 1;
  localparam int SW = PW + 1;
  localparam int RW = SW + 1;
  localparam logic signed [DW-1:0] MAX_V = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] MIN_V = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [RW-1:0] HALF  = RW'(1) <<< (FRAC_BITS - 1);

  function automatic logic signed [DW-1:0] neg_sat(input logic signed [DW-1:0] x);
    return (x == MIN_V) ? MAX_V : -x;
  endfunction

  function automatic logic signed [DW-1:0] sat_rnd(input logic signed [RW-1:0] x);
    logic signed [RW-1:0] y;
    y = (x + HALF) >>> FRAC_BITS;
    if (y > RW'(MAX_V))      return MAX_V;
    else if (y < RW'(MIN_V)) return MIN_V;
    else                     return y[DW-1:0];
  endfunction

  logic                 w_en;
  logic [1:0]           w_rot;
  logic signed [DW-1:0] w_re, w_im, w_op_a, w_op_b;
  logic signed [DW:0]   w_diff;
  logic signed [PW-1:0] w_m, w_pa, w_pb;
  logic signed [SW-1:0] w_re_sum, w_im_sum;
  logic signed [RW-1:0] w_im_fix;

  logic                 r_s1_valid, r_s1_conj;
  logic signed [DW-1:0] r_s1_a, r_s1_b;
  logic [TAG_WIDTH-1:0] r_s1_tag;
  logic                 r_s2_valid, r_s2_conj;
  logic signed [PW-1:0] r_s2_m, r_s2_pa, r_s2_pb;
  logic [TAG_WIDTH-1:0] r_s2_tag;
  logic                 r_out_valid;
  logic [2*DW-1:0]      r_r;
  logic [TAG_WIDTH-1:0] r_out_tag;

  assign w_en       = ~r_out_valid | i_out_ready;
  assign o_in_ready = w_en;
  assign o_out_valid = r_out_valid;
  assign o_r        = r_r;
  assign o_out_tag  = r_out_tag;

  // The conjugate path is A*(-j)^(q+1)*conj(W0) = conj(conj(A*(-j)^(q+1)) * W0),
  // so it shares the input rotation and finishes by negating the imaginary sum.
  assign w_re  = i_a[2*DW-1:DW];
  assign w_im  = i_a[DW-1:0];
  assign w_rot = i_typesel[1:0] + {1'b0, i_typesel[2]};

  always_comb begin
    w_op_a = w_re;
    w_op_b = w_im;
    case (w_rot)
      2'd1:    begin w_op_a = w_im;          w_op_b = neg_sat(w_re); end
      2'd2:    begin w_op_a = neg_sat(w_re); w_op_b = neg_sat(w_im); end
      2'd3:    begin w_op_a = neg_sat(w_im); w_op_b = w_re;          end
      default: ;
    endcase
    if (i_typesel[2]) w_op_b = neg_sat(w_op_b);
  end

  assign w_diff = $signed({r_s1_a[DW-1], r_s1_a}) - $signed({r_s1_b[DW-1], r_s1_b});
  assign w_m    = PW'(C_ONLY)   * PW'(w_diff);
  assign w_pb   = PW'(C_MIN_S)  * PW'(r_s1_b);
  assign w_pa   = PW'(C_PLUS_S) * PW'(r_s1_a);

  // Negation happens at full precision so rounding sees the exact conjugated value.
  assign w_re_sum = SW'(r_s2_m) + SW'(r_s2_pb);
  assign w_im_sum = SW'(r_s2_pa) - SW'(r_s2_m);
  assign w_im_fix = r_s2_conj ? -RW'(w_im_sum) : RW'(w_im_sum);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_conj   <= 1'b0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_tag    <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_conj   <= 1'b0;
      r_s2_m      <= '0;
      r_s2_pa     <= '0;
      r_s2_pb     <= '0;
      r_s2_tag    <= '0;
      r_out_valid <= 1'b0;
      r_r         <= '0;
      r_out_tag   <= '0;
    end else if (w_en) begin
      r_s1_valid  <= i_in_valid;
      r_s1_conj   <= i_typesel[2];
      r_s1_a      <= w_op_a;
      r_s1_b      <= w_op_b;
      r_s1_tag    <= i_tag;
      r_s2_valid  <= r_s1_valid;
      r_s2_conj   <= r_s1_conj;
      r_s2_m      <= w_m;
      r_s2_pa     <= w_pa;
      r_s2_pb     <= w_pb;
      r_s2_tag    <= r_s1_tag;
      r_out_valid <= r_s2_valid;
      r_r         <= {sat_rnd(RW'(w_re_sum)), sat_rnd(w_im_fix)};
      r_out_tag   <= r_s2_tag;
    end
  end

endmodule
